// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-memory responder.
package imem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } imem_state_e;

  // addi x0,x0,0 -- returned in place of data on an illegal fetch
  localparam logic [31:0] IMEM_NOP_WORD = 32'h0000_0013;

  // True when a byte address is not word aligned or falls past the last word.
  function automatic logic addr_illegal(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Instruction-fetch bus between a requester (master) and the memory (slave).
//
// Handshake: the master raises mem_cen_I with mem_addr_I and holds both until a
// cycle with mem_stall_I low follows the request; in that cycle mem_rdata_I and
// mem_err_I are valid. While mem_stall_I is high the master must not advance.
interface imem_responder_if;
  logic        mem_cen_I;
  logic [31:0] mem_addr_I;
  logic        mem_stall_I;
  logic [31:0] mem_rdata_I;
  logic        mem_err_I;

  modport master (
    output mem_cen_I,
    output mem_addr_I,
    input  mem_stall_I,
    input  mem_rdata_I,
    input  mem_err_I
  );

  modport slave (
    input  mem_cen_I,
    input  mem_addr_I,
    output mem_stall_I,
    output mem_rdata_I,
    output mem_err_I
  );
endinterface

// File: rtl/imem_array.sv
// Word storage: synchronous write from the load port, synchronous read on demand.
module imem_array #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [31:0]              wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [31:0]              rdata
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Both ports update on the same edge, so a colliding read sees the old word.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/imem_responder.sv
// Multi-cycle instruction-memory responder: IDLE -> BUSY -> DONE fetch FSM with
// a preload port and alignment/range checking.
module imem_responder
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned LATENCY  = 2,
  parameter logic [31:0] NOP_WORD = IMEM_NOP_WORD
) (
  input  logic                     clk,
  input  logic                     rst,
  imem_responder_if.slave          fetch,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data,
  output imem_state_e              dbg_state
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(LATENCY + 1);

  imem_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   addr_q;
  logic          vld_q;
  logic          nop_q;
  logic          err_q;

  logic [31:0]   cur_addr;
  logic [AW-1:0] cur_idx;
  logic          cur_illegal;
  logic          done_entry;
  logic [31:0]   arr_rdata;

  // With LATENCY==1 the read happens on the accepting edge, before the address
  // is latched, so the live bus address is used while idle.
  always_comb begin
    cur_addr    = (state_q == ST_IDLE) ? fetch.mem_addr_I : addr_q;
    cur_idx     = cur_addr[AW+1:2];
    cur_illegal = addr_illegal(cur_addr, DEPTH);
    done_entry  = 1'b0;
    case (state_q)
      ST_IDLE: done_entry = fetch.mem_cen_I && (LATENCY == 1);
      ST_BUSY: done_entry = (cnt_q == CW'(1));
      default: done_entry = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      vld_q   <= 1'b0;
      nop_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fetch.mem_cen_I) begin
            addr_q  <= fetch.mem_addr_I;
            cnt_q   <= CW'(LATENCY - 1);
            state_q <= (LATENCY == 1) ? ST_DONE : ST_BUSY;
          end
        end
        ST_BUSY: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= ST_DONE;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase

      if (done_entry) begin
        vld_q <= 1'b1;
        nop_q <= cur_illegal;
      end
      err_q <= done_entry && cur_illegal;
    end
  end

  imem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .we    (load_en),
    .waddr (load_addr),
    .wdata (load_data),
    .re    (done_entry && !rst),
    .raddr (cur_idx),
    .rdata (arr_rdata)
  );

  // Stall tracks the request combinationally while idle so stale data is never taken.
  assign fetch.mem_stall_I = (state_q == ST_IDLE) ? fetch.mem_cen_I : (state_q == ST_BUSY);
  assign fetch.mem_rdata_I = !vld_q ? 32'h0 : (nop_q ? NOP_WORD : arr_rdata);
  assign fetch.mem_err_I   = err_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: three instances at LATENCY 1, 2 and 3
// sharing clock, reset and the preload bus.
module tb_imem_responder;
  import imem_pkg::*;

  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_en;
  logic [3:0]  load_addr;
  logic [31:0] load_data;
  imem_state_e st1, st2, st3;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  imem_responder_if f1();
  imem_responder_if f2();
  imem_responder_if f3();

  imem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .fetch(f1), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .dbg_state(st1));
  imem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .fetch(f2), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .dbg_state(st2));
  imem_responder #(.DEPTH(DEPTH), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .fetch(f3), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .dbg_state(st3));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic load_word(input logic [3:0] idx, input logic [31:0] data);
    @(posedge clk); #1;
    load_en = 1'b1; load_addr = idx; load_data = data;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    f1.mem_cen_I = 1'b0; f1.mem_addr_I = '0;
    f2.mem_cen_I = 1'b0; f2.mem_addr_I = '0;
    f3.mem_cen_I = 1'b0; f3.mem_addr_I = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vec_cnt++;
    if (f2.mem_stall_I !== 1'b0) begin miss_cnt++; $display("FAIL reset_stall got=%b exp=0", f2.mem_stall_I); end
    vec_cnt++;
    if (f2.mem_rdata_I !== 32'h0) begin miss_cnt++; $display("FAIL reset_rdata got=%h exp=00000000", f2.mem_rdata_I); end
    vec_cnt++;
    if (f3.mem_err_I !== 1'b0) begin miss_cnt++; $display("FAIL reset_err got=%b exp=0", f3.mem_err_I); end
    vec_cnt++;
    if (st1 !== ST_IDLE) begin miss_cnt++; $display("FAIL reset_state got=%0d exp=%0d", st1, ST_IDLE); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One LATENCY=2 fetch: stall in cycles 0-1, data in cycle 2, request dropped in cycle 3.
  task automatic run_l2(input logic [31:0] addr, input logic [31:0] exp_rdata, input logic exp_err);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      f2.mem_cen_I = 1'b1; f2.mem_addr_I = addr;
      @(negedge clk);
      if (c < 2) begin
        vec_cnt++;
        if (f2.mem_stall_I !== 1'b1) begin miss_cnt++; $display("FAIL l2_stall c%0d got=%b exp=1", c, f2.mem_stall_I); end
        vec_cnt++;
        if (f2.mem_err_I !== 1'b0) begin miss_cnt++; $display("FAIL l2_err_early c%0d got=%b exp=0", c, f2.mem_err_I); end
      end else begin
        vec_cnt++;
        if (f2.mem_stall_I !== 1'b0) begin miss_cnt++; $display("FAIL l2_done_stall got=%b exp=0", f2.mem_stall_I); end
        vec_cnt++;
        if (f2.mem_rdata_I !== exp_rdata) begin miss_cnt++; $display("FAIL l2_rdata addr=%h got=%h exp=%h", addr, f2.mem_rdata_I, exp_rdata); end
        vec_cnt++;
        if (f2.mem_err_I !== exp_err) begin miss_cnt++; $display("FAIL l2_err addr=%h got=%b exp=%b", addr, f2.mem_err_I, exp_err); end
        vec_cnt++;
        if (st2 !== ST_DONE) begin miss_cnt++; $display("FAIL l2_state_done got=%0d exp=%0d", st2, ST_DONE); end
      end
    end
    @(posedge clk); #1;
    f2.mem_cen_I = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (f2.mem_stall_I !== 1'b0) begin miss_cnt++; $display("FAIL l2_idle_stall got=%b exp=0", f2.mem_stall_I); end
    vec_cnt++;
    if (f2.mem_err_I !== 1'b0) begin miss_cnt++; $display("FAIL l2_err_after got=%b exp=0", f2.mem_err_I); end
    vec_cnt++;
    if (f2.mem_rdata_I !== exp_rdata) begin miss_cnt++; $display("FAIL l2_rdata_hold got=%h exp=%h", f2.mem_rdata_I, exp_rdata); end
    vec_cnt++;
    if (st2 !== ST_IDLE) begin miss_cnt++; $display("FAIL l2_state_idle got=%0d exp=%0d", st2, ST_IDLE); end
  endtask

  // One LATENCY=3 fetch with an optional preload of index 5 during cycle load_cyc.
  task automatic run_l3(input logic [31:0] addr, input int load_cyc,
                        input logic [31:0] ld_data, input logic [31:0] exp_rdata);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      f3.mem_cen_I = 1'b1; f3.mem_addr_I = addr;
      load_en = (c == load_cyc); load_addr = 4'd5; load_data = ld_data;
      @(negedge clk);
      if (c < 3) begin
        vec_cnt++;
        if (f3.mem_stall_I !== 1'b1) begin miss_cnt++; $display("FAIL l3_stall c%0d got=%b exp=1", c, f3.mem_stall_I); end
      end else begin
        vec_cnt++;
        if (f3.mem_stall_I !== 1'b0) begin miss_cnt++; $display("FAIL l3_done_stall got=%b exp=0", f3.mem_stall_I); end
        vec_cnt++;
        if (f3.mem_rdata_I !== exp_rdata) begin miss_cnt++; $display("FAIL l3_rdata addr=%h got=%h exp=%h", addr, f3.mem_rdata_I, exp_rdata); end
        vec_cnt++;
        if (st3 !== ST_DONE) begin miss_cnt++; $display("FAIL l3_state_done got=%0d exp=%0d", st3, ST_DONE); end
      end
    end
    @(posedge clk); #1;
    f3.mem_cen_I = 1'b0; load_en = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (st3 !== ST_IDLE) begin miss_cnt++; $display("FAIL l3_state_idle got=%0d exp=%0d", st3, ST_IDLE); end
  endtask

  task automatic test_preload();
    load_word(4'd0,  32'hA000_0000);
    load_word(4'd1,  32'hA111_1111);
    load_word(4'd2,  32'hA222_2222);
    load_word(4'd3,  32'h0050_0093);
    load_word(4'd5,  32'h1111_1111);
    load_word(4'd15, 32'hDEAD_BEEF);
  endtask

  task automatic test_basic();
    run_l2(32'h0000_000C, 32'h0050_0093, 1'b0);
    run_l2(32'h0000_003C, 32'hDEAD_BEEF, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [3];
    logic [31:0] prev;
    words[0] = 32'hA000_0000; words[1] = 32'hA111_1111; words[2] = 32'hA222_2222;
    prev = 32'h0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      f1.mem_cen_I = 1'b1; f1.mem_addr_I = 32'(4 * k);
      @(negedge clk);
      vec_cnt++;
      if (f1.mem_stall_I !== 1'b1) begin miss_cnt++; $display("FAIL b2b_stall k%0d got=%b exp=1", k, f1.mem_stall_I); end
      vec_cnt++;
      if (st1 !== ST_IDLE) begin miss_cnt++; $display("FAIL b2b_bubble k%0d got=%0d exp=%0d", k, st1, ST_IDLE); end
      vec_cnt++;
      if (f1.mem_rdata_I !== prev) begin miss_cnt++; $display("FAIL b2b_hold k%0d got=%h exp=%h", k, f1.mem_rdata_I, prev); end
      @(posedge clk); #1;
      @(negedge clk);
      vec_cnt++;
      if (f1.mem_stall_I !== 1'b0) begin miss_cnt++; $display("FAIL b2b_done_stall k%0d got=%b exp=0", k, f1.mem_stall_I); end
      vec_cnt++;
      if (f1.mem_rdata_I !== words[k]) begin miss_cnt++; $display("FAIL b2b_rdata k%0d got=%h exp=%h", k, f1.mem_rdata_I, words[k]); end
      prev = words[k];
    end
    @(posedge clk); #1;
    f1.mem_cen_I = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (st1 !== ST_IDLE) begin miss_cnt++; $display("FAIL b2b_final_state got=%0d exp=%0d", st1, ST_IDLE); end
  endtask

  task automatic test_errors();
    run_l2(32'h0000_000E, 32'h0000_0013, 1'b1);
    run_l2(32'h0000_0040, 32'h0000_0013, 1'b1);
    run_l2(32'h0000_0004, 32'hA111_1111, 1'b0);
  endtask

  task automatic test_load_collision();
    run_l3(32'h0000_0014, 1, 32'h2222_2222, 32'h2222_2222);
    load_word(4'd5, 32'h1111_1111);
    run_l3(32'h0000_0014, 2, 32'h2222_2222, 32'h1111_1111);
    run_l3(32'h0000_0014, -1, 32'h0, 32'h2222_2222);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    f3.mem_cen_I = 1'b1; f3.mem_addr_I = 32'h0000_000C;
    @(posedge clk); #1;
    rst = 1'b1; f3.mem_cen_I = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (f3.mem_stall_I !== 1'b1) begin miss_cnt++; $display("FAIL rmid_busy_stall got=%b exp=1", f3.mem_stall_I); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (f3.mem_stall_I !== 1'b0) begin miss_cnt++; $display("FAIL rmid_stall got=%b exp=0", f3.mem_stall_I); end
    vec_cnt++;
    if (f3.mem_rdata_I !== 32'h0) begin miss_cnt++; $display("FAIL rmid_rdata got=%h exp=00000000", f3.mem_rdata_I); end
    vec_cnt++;
    if (f3.mem_err_I !== 1'b0) begin miss_cnt++; $display("FAIL rmid_err got=%b exp=0", f3.mem_err_I); end
    vec_cnt++;
    if (st3 !== ST_IDLE) begin miss_cnt++; $display("FAIL rmid_state got=%0d exp=%0d", st3, ST_IDLE); end
    run_l3(32'h0000_000C, -1, 32'h0, 32'h0050_0093);
    run_l3(32'h0000_003C, -1, 32'h0, 32'hDEAD_BEEF);
  endtask

  task automatic test_idle();
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      f2.mem_cen_I = 1'b0; f2.mem_addr_I = $urandom;
      @(negedge clk);
      vec_cnt++;
      if (f2.mem_stall_I !== 1'b0) begin miss_cnt++; $display("FAIL idle_stall i%0d got=%b exp=0", i, f2.mem_stall_I); end
      vec_cnt++;
      if (f2.mem_rdata_I !== 32'h0) begin miss_cnt++; $display("FAIL idle_rdata i%0d got=%h exp=00000000", i, f2.mem_rdata_I); end
      vec_cnt++;
      if (st2 !== ST_IDLE) begin miss_cnt++; $display("FAIL idle_state i%0d got=%0d exp=%0d", i, st2, ST_IDLE); end
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_basic();
    test_back_to_back();
    test_errors();
    test_load_collision();
    test_reset_mid();
    test_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
